// File: rtl/instr_encode_loader.sv
// Instruction loader: packs decoded field bundles into 16-bit words and writes them
// sequentially into instruction memory from address 0.
// Handshake: a bundle transfers on any rising edge where in_valid && in_ready; in_ready is
// high exactly while loading, and in_valid outside LOAD is ignored.
module instr_encode_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_opcode,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rs,
    input  logic [2:0]        in_rt,
    input  logic [8:0]        in_imm,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    logic [1:0]  state;
    logic [15:0] word;
    logic        legal;
    logic        accept;

    assign in_ready = (state == S_LOAD);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == S_LOAD);
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERROR);

    // Format selection by opcode; nzimm opcodes reject an all-zero low immediate.
    always_comb begin
        word  = 16'h0000;
        legal = 1'b1;
        case (in_opcode)
            4'b0010, 4'b0100, 4'b0110, 4'b0111:
                word = {in_opcode, in_rd, in_rs, in_rt, 3'b000};
            4'b0000, 4'b0001:
                word = {in_opcode, in_rt, 2'b00, in_imm[6:0]};
            4'b0011, 4'b0101, 4'b1000, 4'b1001: begin
                word  = {in_opcode, in_rd, in_rs, in_imm[5:0]};
                legal = (in_opcode == 4'b0101) || (in_imm[5:0] != 6'd0);
            end
            4'b1010, 4'b1011:
                word = {in_opcode, in_rs, in_imm};
            default:
                legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 16'h0000;
            count    <= '0;
        end else begin
            im_we <= 1'b0;
            // start wins over a same-cycle accept; that bundle is dropped.
            if (start) begin
                state <= S_LOAD;
                count <= '0;
            end else if (accept) begin
                if (!legal) begin
                    state <= S_ERROR;
                end else begin
                    im_we    <= 1'b1;
                    im_addr  <= count[ADDR_W-1:0];
                    im_wdata <= word;
                    count    <= count + 1'b1;
                    if (in_last || count == LAST_IDX)
                        state <= S_DONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader with a 4-word memory: a reference model predicts the FSM
// and each memory write, and a scoreboard queue matches predicted writes against im_we pulses.
module tb_instr_encode_loader;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [3:0]        in_opcode = '0;
  logic [2:0]        in_rd = '0;
  logic [2:0]        in_rs = '0;
  logic [2:0]        in_rt = '0;
  logic [8:0]        in_imm = '0;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [15:0]       im_wdata;
  logic [ADDR_W:0]   count;
  logic              busy;
  logic              done;
  logic              err;

  int errors = 0;
  int checks = 0;

  int m_state = M_IDLE;
  int m_cnt = 0;
  logic m_we = 1'b0;
  logic [ADDR_W+15:0] exp_q[$];

  instr_encode_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .count(count), .busy(busy), .done(done), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic legal_f(input logic [3:0] op, input logic [8:0] imm);
    if (op >= 4'd12) return 1'b0;
    if (op == 4'd3 || op == 4'd8 || op == 4'd9) return imm[5:0] != 6'd0;
    return 1'b1;
  endfunction

  function automatic logic [15:0] encode_f(input logic [3:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs, input logic [2:0] rt,
                                           input logic [8:0] imm);
    case (op)
      4'd2, 4'd4, 4'd6, 4'd7: return {op, rd, rs, rt, 3'b000};
      4'd0, 4'd1:             return {op, rt, 2'b00, imm[6:0]};
      4'd3, 4'd5, 4'd8, 4'd9: return {op, rd, rs, imm[5:0]};
      4'd10, 4'd11:           return {op, rs, imm};
      default:                return 16'h0000;
    endcase
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, "_we"}, 32'(im_we), 32'(m_we));
    check_eq({tag, "_count"}, 32'(count), 32'(m_cnt));
    check_eq({tag, "_busy"}, 32'(busy), 32'(m_state == M_LOAD));
    check_eq({tag, "_done"}, 32'(done), 32'(m_state == M_DONE));
    check_eq({tag, "_err"}, 32'(err), 32'(m_state == M_ERR));
  endtask

  // driver: one clock cycle of stimulus, model updated before the edge
  task automatic drive_cycle(input logic st, input logic v, input logic l, input logic [3:0] op,
                             input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                             input logic [8:0] imm);
    start = st; in_valid = v; in_last = l;
    in_opcode = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
    check_eq("in_ready", 32'(in_ready), 32'(m_state == M_LOAD));
    m_we = 1'b0;
    if (st) begin
      m_state = M_LOAD;
      m_cnt = 0;
    end else if (v && m_state == M_LOAD) begin
      if (!legal_f(op, imm)) begin
        m_state = M_ERR;
      end else begin
        exp_q.push_back({ADDR_W'(m_cnt), encode_f(op, rd, rs, rt, imm)});
        m_we = 1'b1;
        m_cnt++;
        if (l || m_cnt == DEPTH) m_state = M_DONE;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check_state("cyc");
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_state = M_IDLE; m_cnt = 0; m_we = 1'b0;
    check_state("rst");
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    check_eq("rst_addr", 32'(im_addr), 32'd0);
    check_eq("rst_wdata", 32'(im_wdata), 32'd0);
    check_eq("rst_queue", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard: every write pulse must match the oldest predicted write
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      check_eq("sb_expected_write", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        logic [ADDR_W+15:0] e;
        e = exp_q.pop_front();
        check_eq("sb_addr", 32'(im_addr), 32'(e[ADDR_W+15:16]));
        check_eq("sb_wdata", 32'(im_wdata), 32'(e[15:0]));
      end
    end
  end

  initial begin
    do_reset();

    // basic R-format program of one word
    drive_cycle(1, 0, 0, 4'h0, 0, 0, 0, 0);
    drive_cycle(0, 1, 1, 4'h4, 3'd1, 3'd2, 3'd3, 9'd0);
    check_eq("t1_we", 32'(im_we), 32'd1);
    check_eq("t1_addr", 32'(im_addr), 32'd0);
    check_eq("t1_wdata", 32'(im_wdata), 32'h4298);
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_count", 32'(count), 32'd1);

    // nzimm violation, then restart clears error
    drive_cycle(1, 0, 0, 4'h0, 0, 0, 0, 0);
    drive_cycle(0, 1, 0, 4'h3, 3'd5, 3'd5, 3'd0, 9'd0);
    check_eq("t2_err", 32'(err), 32'd1);
    check_eq("t2_ready", 32'(in_ready), 32'd0);
    check_eq("t2_we", 32'(im_we), 32'd0);
    drive_cycle(1, 0, 0, 4'h0, 0, 0, 0, 0);
    check_eq("t2_err_clr", 32'(err), 32'd0);
    check_eq("t2_busy", 32'(busy), 32'd1);
    check_eq("t2_count", 32'(count), 32'd0);

    // B and M formats
    drive_cycle(0, 1, 0, 4'hA, 3'd0, 3'd7, 3'd0, 9'h1FF);
    check_eq("t3_b_wdata", 32'(im_wdata), 32'hAFFF);
    drive_cycle(0, 1, 1, 4'h0, 3'd0, 3'd0, 3'd2, 9'h045);
    check_eq("t3_m_wdata", 32'(im_wdata), 32'h0445);
    check_eq("t3_m_addr", 32'(im_addr), 32'd1);

    // fill memory: 5 back-to-back legal bundles, only 4 land
    drive_cycle(1, 0, 0, 4'h0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, 1, 0, 4'($urandom_range(0, 11)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  {3'($urandom_range(0, 7)), 6'($urandom_range(1, 63))});
    end
    check_eq("t4_done", 32'(done), 32'd1);
    check_eq("t4_count", 32'(count), 32'd4);
    check_eq("t4_last_addr", 32'(im_addr), 32'd3);

    // illegal opcode, then valid while idle
    drive_cycle(1, 0, 0, 4'h0, 0, 0, 0, 0);
    drive_cycle(0, 1, 0, 4'hF, 3'd1, 3'd1, 3'd1, 9'h1FF);
    check_eq("t5_err", 32'(err), 32'd1);
    do_reset();
    drive_cycle(0, 1, 1, 4'h4, 3'd1, 3'd2, 3'd3, 9'd0);
    check_eq("t5_idle_we", 32'(im_we), 32'd0);

    // start and accept in the same cycle: bundle dropped
    drive_cycle(1, 0, 0, 4'h0, 0, 0, 0, 0);
    drive_cycle(1, 1, 1, 4'h4, 3'd1, 3'd2, 3'd3, 9'd0);
    check_eq("t5_start_prio_we", 32'(im_we), 32'd0);

    // reset right after an accept
    drive_cycle(0, 1, 0, 4'h6, 3'd4, 3'd5, 3'd6, 9'd0);
    do_reset();
    check_eq("t6_busy", 32'(busy), 32'd0);

    // random mix of legal/illegal bundles, gaps and restarts
    for (int i = 0; i < 60; i++) begin
      logic st;
      st = (m_state != M_LOAD) ? 1'b1 : ($urandom_range(0, 15) == 0);
      drive_cycle(st, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  9'($urandom_range(0, 511)));
    end

    @(posedge clk); #1;
    check_eq("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
